// File: rtl/conv_par_ser.sv
// conv_par_ser: byte-wide parallel to serial transmitter, start bit + 8 data bits MSB first + STOP_BITS stop bits.
// A one-entry holding register lets the next byte queue while the current frame shifts out.
module conv_par_ser #(
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] d,
    input  logic       load,
    output logic       out,
    output logic       ready,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam logic [1:0] LAST_STOP = 2'(STOP_BITS - 1);
    state_t     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_valid_q, hold_valid_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] stop_cnt_q, stop_cnt_d;
    logic       done_q, done_d;
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        done_d       = 1'b0;
        if (load && !hold_valid_q) begin
            hold_d       = d;
            hold_valid_d = 1'b1;
        end
        case (state_q)
            IDLE: if (hold_valid_q) begin
                shift_d      = hold_q;
                hold_valid_d = 1'b0;
                state_d      = START;
            end
            START: begin
                state_d   = DATA;
                bit_cnt_d = 3'd0;
            end
            DATA: begin
                shift_d   = {shift_q[6:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d    = STOP;
                    stop_cnt_d = 2'd0;
                end
            end
            STOP: if (stop_cnt_q == LAST_STOP) begin
                done_d = 1'b1;
                // Reload straight into START so queued frames leave no idle gap
                if (hold_valid_q) begin
                    shift_d      = hold_q;
                    hold_valid_d = 1'b0;
                    state_d      = START;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                stop_cnt_d = stop_cnt_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hold_q       <= 8'd0;
            hold_valid_q <= 1'b0;
            shift_q      <= 8'd0;
            bit_cnt_q    <= 3'd0;
            stop_cnt_q   <= 2'd0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            done_q       <= done_d;
        end
    end
    assign out   = (state_q == START) ? 1'b0 : (state_q == DATA) ? shift_q[7] : 1'b1;
    assign ready = !hold_valid_q;
    assign busy  = state_q != IDLE;
    assign done  = done_q;
endmodule

// File: tb/tb_conv_par_ser.sv
// tb_conv_par_ser: directed checks on a STOP_BITS=1 instance plus a loopback receiver
// model scoring random bytes through instances with STOP_BITS 1..4.
module tb_conv_par_ser;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d;
    logic       load_v  [4];
    logic       out_v   [4];
    logic       ready_v [4];
    logic       busy_v  [4];
    logic       done_v  [4];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] sb_q [4][$];
    int         rx_cnt [4];
    logic [7:0] rx_sh  [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        conv_par_ser #(.STOP_BITS(g + 1)) u_dut (
            .clk(clk), .rst_n(rst_n), .d(d), .load(load_v[g]),
            .out(out_v[g]), .ready(ready_v[g]), .busy(busy_v[g]), .done(done_v[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then sample #1 later; the receiver models mimic a falling-edge sampler.
    task automatic step();
        logic       r;
        logic [7:0] e;
        r = rst_n;
        @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            if (!r) begin
                rx_cnt[g] = 0;
                sb_q[g].delete();
            end else if (rx_cnt[g] == 0) begin
                if (out_v[g] === 1'b0) rx_cnt[g] = 1;
            end else begin
                rx_sh[g] = {rx_sh[g][6:0], out_v[g]};
                if (rx_cnt[g] == 8) begin
                    if (sb_q[g].size() != 0) e = sb_q[g].pop_front();
                    else e = 8'hxx;
                    chk($sformatf("rx%0d_byte", g), {24'd0, rx_sh[g]}, {24'd0, e});
                    rx_cnt[g] = 0;
                end else begin
                    rx_cnt[g]++;
                end
            end
        end
    endtask

    function automatic logic all_ready();
        return ready_v[0] & ready_v[1] & ready_v[2] & ready_v[3];
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] fr;
        logic [7:0] b1;
        logic [7:0] rb;
        int         w;
        foreach (load_v[g]) load_v[g] = 1'b0;
        foreach (rx_cnt[g]) begin rx_cnt[g] = 0; rx_sh[g] = 8'd0; end
        // Reset with load held high: the byte must not be captured
        rst_n = 1'b0; d = 8'h77; load_v[0] = 1'b1;
        step(); step();
        chk("rst_out", out_v[0], 1); chk("rst_ready", ready_v[0], 1);
        chk("rst_busy", busy_v[0], 0); chk("rst_done", done_v[0], 0);
        chk("rst_out_sb4", out_v[3], 1);
        rst_n = 1'b1; load_v[0] = 1'b0;
        step();
        chk("post_rst_ready", ready_v[0], 1); chk("post_rst_out", out_v[0], 1);
        chk("post_rst_busy", busy_v[0], 0);
        // Single frame 8'hA5
        d = 8'hA5; load_v[0] = 1'b1; sb_q[0].push_back(8'hA5);
        step();
        load_v[0] = 1'b0;
        chk("a5_e0_ready", ready_v[0], 0); chk("a5_e0_out", out_v[0], 1); chk("a5_e0_busy", busy_v[0], 0);
        fr = {1'b0, 8'hA5, 1'b1};
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("a5_out_e%0d", k), out_v[0], fr[10-k]);
            chk("a5_busy", busy_v[0], 1); chk("a5_done_low", done_v[0], 0);
        end
        step();
        chk("a5_e11_out", out_v[0], 1); chk("a5_e11_busy", busy_v[0], 0); chk("a5_e11_done", done_v[0], 1);
        step();
        chk("a5_e12_done", done_v[0], 0);
        // Back-to-back 3C then FF, with an overflow load of 55 while hold is full
        b1 = 8'h3C;
        d = 8'h3C; load_v[0] = 1'b1; sb_q[0].push_back(8'h3C);
        step();
        load_v[0] = 1'b0;
        step();
        chk("b2b_e1_out", out_v[0], 0); chk("b2b_e1_ready", ready_v[0], 1);
        d = 8'hFF; load_v[0] = 1'b1; sb_q[0].push_back(8'hFF);
        step();
        load_v[0] = 1'b0;
        chk("b2b_e2_ready", ready_v[0], 0);
        for (int k = 3; k <= 22; k++) begin
            step();
            chk($sformatf("b2b_ready_e%0d", k), ready_v[0], (k <= 10) ? 1'b0 : 1'b1);
            chk($sformatf("b2b_done_e%0d", k), done_v[0], (k == 11 || k == 21) ? 1'b1 : 1'b0);
            chk($sformatf("b2b_out_e%0d", k), out_v[0], (k <= 9) ? b1[9-k] : (k == 11) ? 1'b0 : 1'b1);
            chk($sformatf("b2b_busy_e%0d", k), busy_v[0], (k <= 20) ? 1'b1 : 1'b0);
            if (k == 4) begin d = 8'h55; load_v[0] = 1'b1; end
            if (k == 5) begin d = 8'h00; load_v[0] = 1'b0; end
        end
        // Reset during data bit 4 of F0 with 81 queued behind it
        d = 8'hF0; load_v[0] = 1'b1; sb_q[0].push_back(8'hF0);
        step();
        load_v[0] = 1'b0;
        step();
        d = 8'h81; load_v[0] = 1'b1; sb_q[0].push_back(8'h81);
        step();
        load_v[0] = 1'b0;
        repeat (4) step();
        chk("f0_bit4", out_v[0], 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_out", out_v[0], 1); chk("abort_busy", busy_v[0], 0);
        chk("abort_ready", ready_v[0], 1); chk("abort_done", done_v[0], 0);
        for (int k = 0; k < 12; k++) begin
            step();
            chk("abort_idle_out", out_v[0], 1); chk("abort_no_done", done_v[0], 0);
        end
        // Loopback: 100 random bytes through all four stop-bit variants
        for (int i = 0; i < 100; i++) begin
            w = 0;
            while (!all_ready() && w < 200) begin step(); w++; end
            chk("lb_ready", all_ready(), 1);
            rb = 8'($urandom);
            d = rb;
            for (int g = 0; g < 4; g++) begin load_v[g] = 1'b1; sb_q[g].push_back(rb); end
            step();
            foreach (load_v[g]) load_v[g] = 1'b0;
        end
        repeat (40) step();
        for (int g = 0; g < 4; g++) chk($sformatf("lb_drain%0d", g), sb_q[g].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
